// File: rtl/bk_seq_add_wide.sv
// Multi-cycle WIDTH-bit adder: sequences byte slices LSB-first through a single
// BKadd8 instance, with the slice carry held in a register between cycles.

module BKadd8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);
    logic [7:0] g;
    logic [7:0] p;
    logic       g10, p10, g32, p32, g54, p54, g76, p76;
    logic       g30, p30, g74, p74, g70, p70;
    logic       g50, p50, g20, p20, g40, p40, g60, p60;
    logic [7:0] grp_g;
    logic [7:0] grp_p;
    logic [8:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Up-sweep: pairwise, then quads, then the full byte
    assign g10 = g[1] | (p[1] & g[0]);
    assign p10 = p[1] & p[0];
    assign g32 = g[3] | (p[3] & g[2]);
    assign p32 = p[3] & p[2];
    assign g54 = g[5] | (p[5] & g[4]);
    assign p54 = p[5] & p[4];
    assign g76 = g[7] | (p[7] & g[6]);
    assign p76 = p[7] & p[6];
    assign g30 = g32 | (p32 & g10);
    assign p30 = p32 & p10;
    assign g74 = g76 | (p76 & g54);
    assign p74 = p76 & p54;
    assign g70 = g74 | (p74 & g30);
    assign p70 = p74 & p30;

    // Down-sweep fills in the remaining prefixes
    assign g50 = g54 | (p54 & g30);
    assign p50 = p54 & p30;
    assign g20 = g[2] | (p[2] & g10);
    assign p20 = p[2] & p10;
    assign g40 = g[4] | (p[4] & g30);
    assign p40 = p[4] & p30;
    assign g60 = g[6] | (p[6] & g50);
    assign p60 = p[6] & p50;

    assign grp_g = {g70, g60, g50, g40, g30, g20, g10, g[0]};
    assign grp_p = {p70, p60, p50, p40, p30, p20, p10, p[0]};

    assign c[0]   = cin;
    assign c[8:1] = grp_g | (grp_p & {8{cin}});

    assign s    = p ^ c[7:0];
    assign cout = c[8];
endmodule

module bk_seq_add_wide #(
    parameter  int unsigned NSLICE = 4,
    localparam int unsigned WIDTH  = 8 * NSLICE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int unsigned CW = $clog2(NSLICE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [7:0]       slice_a;
    logic [7:0]       slice_b;
    logic [7:0]       slice_s;
    logic             slice_co;

    assign slice_a = a_q[{cnt_q, 3'b000} +: 8];
    assign slice_b = b_q[{cnt_q, 3'b000} +: 8];

    BKadd8 u_bkadd8 (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_co)
    );

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = a;
                    b_d        = b;
                    carry_d    = cin;
                    cnt_d      = '0;
                    state_d    = S_RUN;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            S_RUN: begin
                sum_d[{cnt_q, 3'b000} +: 8] = slice_s;
                carry_d                     = slice_co;
                if (cnt_q == CW'(NSLICE - 1)) begin
                    cout_d      = slice_co;
                    cnt_d       = '0;
                    state_d     = S_DONE;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign busy      = busy_q;
endmodule
